// File: rtl/onchipmem_sample_reader.sv
// onchipmem_sample_reader: Avalon-MM read master that streams stereo PCM words through a small FIFO.
// Define SAMPLE_READER_LOOP_EN to add a loop input that replays the window until stop.
module onchipmem_sample_reader #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
`ifdef SAMPLE_READER_LOOP_EN
  input  logic              loop,
`endif
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [15:0]       sample_left,
  output logic [15:0]       sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_W = 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] base_q, cur, last;
  logic [ADDR_W:0]   words_q, rem;
  logic loop_q, inflight, zero_done, issue, empty, last_word, accept, abort, push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0] fifo [FIFO_DEPTH];
  assign accept    = state == IDLE && start && !stop;
  assign abort     = state != IDLE && stop;
  assign empty     = count == '0 && !inflight;
  assign last_word = rem == ONE_W;
  assign push      = inflight;
  assign pop       = sample_valid && sample_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else if (accept && num_words != '0) state_nxt = FETCH;
    else if (state == FETCH && issue && last_word && !loop_q) state_nxt = DRAIN;
    else if (state == DRAIN && empty) state_nxt = IDLE;
  end
  // A read is allowed only while FIFO slots not yet claimed by data or an in-flight read remain.
  always_comb begin
    issue          = state == FETCH && !stop && (count + CW'(inflight)) < CW'(FIFO_DEPTH);
    mem_chipselect = issue;
    mem_address    = issue ? cur : last;
    busy           = state != IDLE;
    done           = zero_done || (state == DRAIN && empty && !stop);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_clken <= 1'b0;
      base_q    <= '0;
      words_q   <= '0;
      cur       <= '0;
      last      <= '0;
      rem       <= '0;
      inflight  <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      mem_clken <= 1'b1;
      zero_done <= accept && num_words == '0;
      inflight  <= issue;
      if (accept) begin
        base_q  <= base_addr;
        words_q <= num_words;
        cur     <= base_addr;
        rem     <= num_words;
      end else if (issue) begin
        last <= cur;
        cur  <= last_word && loop_q ? base_q : cur + ONE_A;
        rem  <= last_word && loop_q ? words_q : rem - ONE_W;
      end
    end
`ifdef SAMPLE_READER_LOOP_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) loop_q <= 1'b0;
    else if (accept) loop_q <= loop;
`else
  assign loop_q = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= mem_readdata;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  assign sample_valid = count != '0;
  assign sample_left  = fifo[rd_ptr][31:16];
  assign sample_right = fifo[rd_ptr][15:0];
endmodule

// File: tb/tb_onchipmem_sample_reader.sv
// tb_onchipmem_sample_reader: scoreboard bench; a memory model answers reads, expected pairs/addresses are queued at start.
module tb_onchipmem_sample_reader;
  logic clk = 0, reset_n = 0, start = 0, stop = 0, sample_ready = 0;
  logic [15:0] base_addr = 0;
  logic [16:0] num_words = 0;
  logic [15:0] mem_address, sample_left, sample_right;
  logic mem_chipselect, mem_clken, sample_valid, busy, done;
  logic [31:0] mem_readdata = 0;
`ifdef SAMPLE_READER_LOOP_EN
  logic loop = 0;
`endif
  logic [31:0] mem_model [65536];
  logic [31:0] exp_q[$];
  logic [15:0] addr_q[$];
  int total = 0, bad = 0, cyc = 0, last_pop_cyc = 0, done_cyc = 0, done_cnt = 0;
  int cs_cnt = 0, pops = 0, n_iss = 0, n_pop = 0, ready_mode = 0;
  logic hold = 0;
  logic [31:0] hold_data = 0;

  always #5 clk = ~clk;

  onchipmem_sample_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
`ifdef SAMPLE_READER_LOOP_EN
    .loop(loop),
`endif
    .base_addr(base_addr), .num_words(num_words),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy), .done(done)
  );

  always @(posedge clk) if (mem_chipselect) mem_readdata <= mem_model[mem_address];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: sample_ready = 1'b1;
      1: sample_ready = (cyc % 4) == 0;
      2: sample_ready = $urandom_range(0, 1) == 1;
      default: sample_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (hold) begin
        chk("hold_valid", sample_valid, 1);
        chk("hold_data", {sample_left, sample_right}, hold_data);
      end
      if (mem_chipselect) begin
        cs_cnt++;
        chk("occupancy_lt4", n_iss - n_pop < 4, 1);
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL addr_unexpected: got %h want no read", mem_address);
        end else chk("addr", mem_address, addr_q.pop_front());
        n_iss++;
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pair_unexpected: got %h want no pair", {sample_left, sample_right});
        end else chk("pair", {sample_left, sample_right}, exp_q.pop_front());
        n_pop++; pops++; last_pop_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      hold = sample_valid && !sample_ready;
      hold_data = {sample_left, sample_right};
    end else hold = 0;
  end

  task automatic go(input logic [15:0] b, input logic [16:0] n, input bit track);
    if (track) for (int i = 0; i < int'(n); i++) begin
      logic [15:0] a;
      a = b + 16'(i);
      addr_q.push_back(a);
      exp_q.push_back(mem_model[a]);
    end
    base_addr = b; num_words = n; start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 3000);
    chk({name, "_done_seen"}, done, 1);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_busy_low"}, busy, 0);
    chk({name, "_done_after_last"}, done_cyc, last_pop_cyc + 1);
    chk({name, "_pairs_left"}, exp_q.size(), 0);
    chk({name, "_addrs_left"}, addr_q.size(), 0);
  endtask

  task automatic flush_model();
    exp_q.delete(); addr_q.delete();
    n_iss = 0; n_pop = 0; hold = 0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_address"}, mem_address, 0);
    chk({name, "_cs"}, mem_chipselect, 0);
    chk({name, "_clken"}, mem_clken, 0);
    chk({name, "_left"}, sample_left, 0);
    chk({name, "_right"}, sample_right, 0);
    chk({name, "_valid"}, sample_valid, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  initial begin
    int cs0, pops0, done0;
    for (int i = 0; i < 65536; i++) mem_model[i] = $urandom;
    for (int i = 0; i < 8; i++) mem_model[16 + i] = 32'h0001_0002 + 32'(i) * 32'h0002_0002;
    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    tick(1);
    chk("clken_on", mem_clken, 1);

    ready_mode = 0;
    go(16'h0010, 8, 1);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    wait_done("basic");

    ready_mode = 1;
    go(16'h0010, 8, 1);
    wait_done("backpressure");

    ready_mode = 2;
    go(16'hFFFE, 4, 1);
    wait_done("wrap");

    ready_mode = 0;
    tick(1);
    cs0 = cs_cnt;
    go(16'h0100, 0, 1);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    chk("zero_no_cs", cs_cnt, cs0);

    tick(1);
    pops0 = pops;
    go(16'h0200, 6, 1);
    tick(2);
    go(16'h0900, 5, 0);
    wait_done("busy_start");
    chk("busy_start_pairs", pops - pops0, 6);

    for (int r = 0; r < 6; r++) begin
      logic [15:0] b;
      tick(1);
      ready_mode = $urandom_range(0, 2);
      b = (r % 2 == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
      go(b, 17'($urandom_range(1, 20)), 1);
      wait_done("random");
    end

    tick(1);
    ready_mode = 3;
    done0 = done_cnt;
    go(16'h0300, 100, 1);
    tick(2);
    stop = 1;
    tick(1);
    stop = 0;
    flush_model();
    @(negedge clk);
    chk("abort_valid", sample_valid, 0);
    chk("abort_busy", busy, 0);
    cs0 = cs_cnt;
    tick(5);
    chk("abort_no_done", done_cnt, done0);
    chk("abort_no_cs", cs_cnt, cs0);

    ready_mode = 2;
    go(16'h0400, 50, 1);
    tick(5);
    #2 reset_n = 0;
    flush_model();
    #1 chk_all_zero("async_reset");
    tick(2);
    reset_n = 1;
    tick(1);
    ready_mode = 0;
    go(16'h0010, 8, 1);
    wait_done("after_reset");

`ifdef SAMPLE_READER_LOOP_EN
    tick(1);
    done0 = done_cnt;
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a;
      a = 16'h0020 + 16'(i % 3);
      addr_q.push_back(a);
      exp_q.push_back(mem_model[a]);
    end
    loop = 1;
    base_addr = 16'h0020; num_words = 3; start = 1;
    tick(1);
    start = 0; loop = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("loop_seam_cs", mem_chipselect, 1);
    end
    tick(1);
    stop = 1;
    tick(1);
    stop = 0;
    flush_model();
    @(negedge clk);
    chk("loop_stop_busy", busy, 0);
    tick(3);
    chk("loop_no_done", done_cnt, done0);
`endif

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onchipmem_sample_reader.md
Name: onchipmem_sample_reader

Overview:
- Avalon-MM read master that streams stereo PCM words out of the 64K x 32 single-port on-chip sample memory into the codec playback path.
- Fetches a programmed window of words from the memory and buffers them in a small FIFO.
- Presents each word as a left/right 16-bit sample pair on a valid/ready stream.
- Sits between the on-chip memory slave (upstream) and the codec DAC serialiser (downstream).

Parameters:
- ADDR_W, 16, memory word-address width.
- FIFO_DEPTH, 4, sample-pair buffer depth; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; begin playback of the programmed window.
- stop  in  1  one-cycle pulse; abort playback.
- base_addr  in  ADDR_W  first word address, sampled on start.
- num_words  in  ADDR_W+1  words to play, sampled on start; range 0..65536.
- mem_address  out  ADDR_W  memory word address.
- mem_chipselect  out  1  read strobe; memory write is never driven.
- mem_clken  out  1  memory clock enable; constant 1 outside reset.
- mem_readdata  in  32  memory data; valid the cycle after the address is presented.
- sample_left  out  16  left sample, taken from readdata[31:16].
- sample_right  out  16  right sample, taken from readdata[15:0].
- sample_valid  out  1  FIFO head is valid.
- sample_ready  in  1  downstream accepts the head.
- busy  out  1  high in FETCH or DRAIN.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; FIFO and in-flight flag cleared.
- Reset values: mem_address 0, mem_chipselect 0, mem_clken 0, sample_left 0, sample_right 0, sample_valid 0, busy 0, done 0.
- Memory timing: read latency is exactly 1 cycle. An address presented with chipselect in cycle N returns readdata in cycle N+1. The block sets an in-flight flag in cycle N and pushes readdata into the FIFO in cycle N+1.
- Issue rule: a read is issued in a cycle only when (fifo_count + inflight) < FIFO_DEPTH and words remain. The FIFO therefore never overflows.
- A stall-free downstream sustains 1 pair per cycle.
- Address arithmetic: the address starts at base_addr and increments by 1 per issued read, modulo 2^ADDR_W. Example: base 0xFFFF wraps to 0x0000.
- IDLE:
  - start with num_words != 0: latch base_addr and num_words, go to FETCH, busy=1 from the next cycle.
  - start with num_words == 0: pulse done next cycle and stay in IDLE.
- FETCH: issue reads per the issue rule and decrement the remaining count. After the last read is issued, go to DRAIN.
- DRAIN: when the FIFO is empty and no read is in flight, pulse done for one cycle, go to IDLE, busy=0.
- Stream handshake:
  - A pair transfers when sample_valid && sample_ready.
  - sample_left and sample_right hold stable while valid is high and ready is low.
  - Push and pop in the same cycle leave fifo_count unchanged.
- stop in FETCH or DRAIN:
  - Next cycle: state IDLE, FIFO flushed, sample_valid=0, busy=0, done not pulsed.
  - A response already in flight is discarded.
- Simultaneous events:
  - stop and start together in IDLE: stop wins, block stays IDLE.
  - start while busy: ignored.
- mem_chipselect is low whenever no read is issued. mem_address holds its last value in that case.

Optional Feature:
- Macro: SAMPLE_READER_LOOP_EN
- Defined: adds input port loop (1 bit), sampled on start. With loop=1, after the read of the last window word the address reloads to the latched base_addr and the remaining count reloads to num_words. FETCH continues without a gap or bubble. DRAIN and done occur only via stop, which still flushes and suppresses done.
- Not defined: no loop port; one-shot behaviour as above.

Test Plan:
- Basic playback: memory words 0..7 = 0x0001_0002 + i*0x0002_0002; base 0x0010, num_words 8, ready held 1. Expect 8 pairs in order, starting left=0x0001 right=0x0002. Expect done pulse 1 cycle after the last transfer, busy low thereafter.
- Backpressure: same window, ready toggles 1 cycle on / 3 off. Expect data held stable while stalled, no pair lost or duplicated. Expect mem_chipselect low whenever fifo_count + inflight = 4.
- Wrap-around: base 0xFFFE, num_words 4. Expect addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Zero length and busy start: num_words 0 gives done next cycle with no chipselect ever high. A second start during FETCH is ignored, with exactly the first window played.
- Abort: stop 3 cycles into a 100-word window with ready=0. Expect sample_valid=0 and busy=0 next cycle, no done pulse. Drive reset_n low mid-FETCH: expect all outputs 0 immediately, without waiting for a clock edge.
- Loop (SAMPLE_READER_LOOP_EN): base 0x0020, num_words 3, loop=1. Expect address sequence 0x20, 0x21, 0x22, 0x20, ... with no idle cycle at the seam. stop ends playback with no done pulse.
